// File: rtl/sparrow_lsu_pkg.sv
// rtl/sparrow_lsu_pkg.sv - shared types and helpers for the load/store unit
package sparrow_lsu_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        DWORD     = 2'b10,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] size_bytes(mem_access_size_e size);
        case (size)
            BYTE:      return 4'd1;
            HALF_WORD: return 4'd2;
            WORD:      return 4'd4;
            default:   return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/sparrow_lsu_align.sv
// rtl/sparrow_lsu_align.sv - lane shifting for stores and merge/extension for loads
// Ports:
//   size_i, zext_i, ofs_i   access size, zero-extend flag, byte offset within a bus word
//   wdata_i                 right-justified store data
//   beat0_i, beat1_i        captured read data of the first/second beat
//   be0_o, be1_o            byte enables for beat 0 / beat 1
//   wdata0_o, wdata1_o      lane-shifted store data for beat 0 / beat 1
//   load_o                  selected load bytes, zero- or sign-extended to XLEN
module sparrow_lsu_align
    import sparrow_lsu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BYTES = XLEN / 8,
    parameter int unsigned OFS_W = $clog2(BYTES)
) (
    input  mem_access_size_e   size_i,
    input  logic               zext_i,
    input  logic [OFS_W-1:0]   ofs_i,
    input  logic [XLEN-1:0]    wdata_i,
    input  logic [XLEN-1:0]    beat0_i,
    input  logic [XLEN-1:0]    beat1_i,
    output logic [BYTES-1:0]   be0_o,
    output logic [BYTES-1:0]   be1_o,
    output logic [XLEN-1:0]    wdata0_o,
    output logic [XLEN-1:0]    wdata1_o,
    output logic [XLEN-1:0]    load_o
);

    logic [3:0]          nbytes;
    logic [6:0]          nbits;
    logic [2*BYTES-1:0]  lane_mask;
    logic [2*XLEN-1:0]   wide_wdata;
    logic [2*XLEN-1:0]   merged;
    logic [2*XLEN-1:0]   keep;
    logic [2*XLEN-1:0]   extended;
    logic                sign;

    always_comb begin
        nbytes = size_bytes(size_i);
        nbits  = {nbytes, 3'b000};

        // Both beats are viewed as one 2*BYTES window: beat 0 takes the low half, beat 1 the high half.
        lane_mask  = (~({2*BYTES{1'b1}} << nbytes)) << ofs_i;
        wide_wdata = {{XLEN{1'b0}}, wdata_i} << {ofs_i, 3'b000};

        merged = {beat1_i, beat0_i} >> {ofs_i, 3'b000};
        keep   = ~({2*XLEN{1'b1}} << nbits);
        // keep & ~(keep >> 1) isolates the MSB of the selected bytes without a variable index.
        sign   = |(merged & keep & ~(keep >> 1));

        if (zext_i || !sign) begin
            extended = merged & keep;
        end else begin
            extended = merged | ~keep;
        end

        be0_o    = lane_mask[BYTES-1:0];
        be1_o    = lane_mask[2*BYTES-1:BYTES];
        wdata0_o = wide_wdata[XLEN-1:0];
        wdata1_o = wide_wdata[2*XLEN-1:XLEN];
        load_o   = extended[XLEN-1:0];
    end

endmodule

// File: rtl/sparrow_lsu.sv
// rtl/sparrow_lsu.sv - load/store unit: request FSM, capture registers, bus beat sequencing
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   lsu_req_i/wr_i/size_i/zext_i    core request (sampled only when idle)
//   lsu_addr_i, lsu_wdata_i         byte address, right-justified store data
//   lsu_busy_o                      high whenever not idle
//   lsu_rvalid_o/rdata_o/err_o      one-cycle completion with extended load data and error flag
//   data_req_o/we_o/be_o/addr_o/wdata_o   bus beat request, held until data_gnt_i
//   data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i   bus grant and in-order response
module sparrow_lsu
    import sparrow_lsu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter bit          SPLIT_MISALIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lsu_req_i,
    input  logic                   lsu_wr_i,
    input  mem_access_size_e       lsu_size_i,
    input  logic                   lsu_zext_i,
    input  logic [ADDR_W-1:0]      lsu_addr_i,
    input  logic [XLEN-1:0]        lsu_wdata_i,
    output logic                   lsu_busy_o,
    output logic                   lsu_rvalid_o,
    output logic [XLEN-1:0]        lsu_rdata_o,
    output logic                   lsu_err_o,
    output logic                   data_req_o,
    output logic                   data_we_o,
    output logic [XLEN/8-1:0]      data_be_o,
    output logic [ADDR_W-1:0]      data_addr_o,
    output logic [XLEN-1:0]        data_wdata_o,
    input  logic                   data_gnt_i,
    input  logic                   data_rvalid_i,
    input  logic [XLEN-1:0]        data_rdata_i,
    input  logic                   data_err_i
);

    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFS_W = $clog2(BYTES);

    lsu_state_e         state_q, state_d;
    logic               wr_q, wr_d;
    mem_access_size_e   size_q, size_d;
    logic               zext_q, zext_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]    wdata_q, wdata_d;
    logic [XLEN-1:0]    beat0_q, beat0_d;
    logic [XLEN-1:0]    beat1_q, beat1_d;
    logic               split_q, split_d;
    logic               err_q, err_d;

    logic [4:0]         req_end;
    logic               req_split;
    logic               req_illegal;

    // Decode of the live request, only consumed in IDLE.
    assign req_end     = 5'(lsu_addr_i[OFS_W-1:0]) + 5'(size_bytes(lsu_size_i));
    assign req_split   = (req_end > 5'(BYTES));
    assign req_illegal = (lsu_size_i == DWORD) && (XLEN != 64);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        size_d  = size_q;
        zext_d  = zext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        split_d = split_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    wr_d    = lsu_wr_i;
                    size_d  = lsu_size_i;
                    zext_d  = lsu_zext_i;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                    beat0_d = '0;
                    beat1_d = '0;
                    split_d = req_split;
                    if (req_illegal || (req_split && !SPLIT_MISALIGNED)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = REQ0;
                    end
                end
            end
            REQ0: if (data_gnt_i) state_d = WAIT0;
            WAIT0: begin
                if (data_rvalid_i) begin
                    beat0_d = data_rdata_i;
                    if (data_err_i) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (split_q) begin
                        state_d = REQ1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            REQ1: if (data_gnt_i) state_d = WAIT1;
            WAIT1: begin
                if (data_rvalid_i) begin
                    beat1_d = data_rdata_i;
                    err_d   = err_q | data_err_i;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= BYTE;
            zext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            zext_q  <= zext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
            split_q <= split_d;
            err_q   <= err_d;
        end
    end

    logic [BYTES-1:0]  be0, be1;
    logic [XLEN-1:0]   wdata0, wdata1, load_data;
    logic [ADDR_W-1:0] beat0_addr, beat1_addr;
    logic              in_req, second;

    sparrow_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .size_i   (size_q),
        .zext_i   (zext_q),
        .ofs_i    (addr_q[OFS_W-1:0]),
        .wdata_i  (wdata_q),
        .beat0_i  (beat0_q),
        .beat1_i  (beat1_q),
        .be0_o    (be0),
        .be1_o    (be1),
        .wdata0_o (wdata0),
        .wdata1_o (wdata1),
        .load_o   (load_data)
    );

    assign beat0_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign beat1_addr = beat0_addr + ADDR_W'(BYTES);

    // Bus outputs decode straight from state so an asynchronous reset drops data_req_o at once.
    assign in_req       = (state_q == REQ0) || (state_q == REQ1);
    assign second       = (state_q == REQ1);
    assign data_req_o   = in_req;
    assign data_we_o    = in_req & wr_q;
    assign data_be_o    = in_req ? (second ? be1 : be0) : '0;
    assign data_addr_o  = in_req ? (second ? beat1_addr : beat0_addr) : '0;
    assign data_wdata_o = in_req ? (second ? wdata1 : wdata0) : '0;

    assign lsu_busy_o   = (state_q != IDLE);
    assign lsu_rvalid_o = (state_q == RESP);
    assign lsu_err_o    = (state_q == RESP) & err_q;
    assign lsu_rdata_o  = ((state_q == RESP) && !wr_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_sparrow_lsu.sv
// tb/tb_sparrow_lsu.sv - directed self-checking bench for sparrow_lsu
module tb_sparrow_lsu;
    import sparrow_lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       req_v;
    logic             wr, zext;
    mem_access_size_e size;
    logic [31:0]      addr;
    logic [63:0]      wdata;
    logic             gnt, rvalid, berr;
    logic [63:0]      bus_rdata;

    logic        a_busy, a_rv, a_err, a_req, a_we;
    logic [31:0] a_rdata, a_addr, a_wdata;
    logic [3:0]  a_be;
    logic        b_busy, b_rv, b_err, b_req, b_we;
    logic [31:0] b_rdata, b_addr, b_wdata;
    logic [3:0]  b_be;
    logic        c_busy, c_rv, c_err, c_req, c_we;
    logic [63:0] c_rdata, c_wdata;
    logic [31:0] c_addr;
    logic [7:0]  c_be;

    sparrow_lsu #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .lsu_req_i(req_v[0]), .lsu_wr_i(wr), .lsu_size_i(size),
        .lsu_zext_i(zext), .lsu_addr_i(addr), .lsu_wdata_i(wdata[31:0]), .lsu_busy_o(a_busy),
        .lsu_rvalid_o(a_rv), .lsu_rdata_o(a_rdata), .lsu_err_o(a_err), .data_req_o(a_req),
        .data_we_o(a_we), .data_be_o(a_be), .data_addr_o(a_addr), .data_wdata_o(a_wdata),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(bus_rdata[31:0]), .data_err_i(berr));

    sparrow_lsu #(.XLEN(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .lsu_req_i(req_v[1]), .lsu_wr_i(wr), .lsu_size_i(size),
        .lsu_zext_i(zext), .lsu_addr_i(addr), .lsu_wdata_i(wdata[31:0]), .lsu_busy_o(b_busy),
        .lsu_rvalid_o(b_rv), .lsu_rdata_o(b_rdata), .lsu_err_o(b_err), .data_req_o(b_req),
        .data_we_o(b_we), .data_be_o(b_be), .data_addr_o(b_addr), .data_wdata_o(b_wdata),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(bus_rdata[31:0]), .data_err_i(berr));

    sparrow_lsu #(.XLEN(64), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .lsu_req_i(req_v[2]), .lsu_wr_i(wr), .lsu_size_i(size),
        .lsu_zext_i(zext), .lsu_addr_i(addr), .lsu_wdata_i(wdata), .lsu_busy_o(c_busy),
        .lsu_rvalid_o(c_rv), .lsu_rdata_o(c_rdata), .lsu_err_o(c_err), .data_req_o(c_req),
        .data_we_o(c_we), .data_be_o(c_be), .data_addr_o(c_addr), .data_wdata_o(c_wdata),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(bus_rdata), .data_err_i(berr));

    int          sel = 0;
    logic        m_busy, m_rv, m_err, m_req, m_we;
    logic [63:0] m_rdata, m_wdata;
    logic [31:0] m_addr;
    logic [7:0]  m_be;

    always_comb begin
        m_busy = a_busy; m_rv = a_rv; m_err = a_err; m_req = a_req; m_we = a_we;
        m_rdata = {32'h0, a_rdata}; m_wdata = {32'h0, a_wdata}; m_addr = a_addr; m_be = {4'h0, a_be};
        if (sel == 1) begin
            m_busy = b_busy; m_rv = b_rv; m_err = b_err; m_req = b_req; m_we = b_we;
            m_rdata = {32'h0, b_rdata}; m_wdata = {32'h0, b_wdata}; m_addr = b_addr; m_be = {4'h0, b_be};
        end else if (sel == 2) begin
            m_busy = c_busy; m_rv = c_rv; m_err = c_err; m_req = c_req; m_we = c_we;
            m_rdata = c_rdata; m_wdata = c_wdata; m_addr = c_addr; m_be = c_be;
        end
    end

    int cyc = 0, req_cnt = 0, rv_cnt = 0;
    int t0 = 0, lat = 0, rc = 0;
    int n_checks = 0, n_fail = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_req) req_cnt <= req_cnt + 1;
        if (m_rv)  rv_cnt  <= rv_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a negedge; pulses the request of one instance for one rising edge.
    task automatic start(input int inst, input logic w, input mem_access_size_e s,
                         input logic z, input logic [31:0] a, input logic [63:0] d);
        sel = inst; wr = w; size = s; zext = z; addr = a; wdata = d;
        req_v = 3'b000;
        req_v[inst] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req_v = 3'b000;
    endtask

    task automatic beat(input string tag, input logic [31:0] ea, input logic [7:0] ebe,
                        input logic ewe, input logic [63:0] ewd, input logic [63:0] rd,
                        input logic e, input int hold);
        int n = 0;
        logic stable = 1'b1;
        while (!m_req && n < 20) begin @(negedge clk); n++; end
        check({tag, "_req"}, m_req, 1);
        check({tag, "_addr"}, m_addr, ea);
        check({tag, "_be"}, m_be, ebe);
        check({tag, "_we"}, m_we, ewe);
        check({tag, "_wdata"}, m_wdata, ewd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(m_req && m_busy && m_addr == ea && m_be == ebe)) stable = 1'b0;
        end
        if (hold > 0) check({tag, "_hold_stable"}, stable, 1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; bus_rdata = rd; berr = e;
        @(negedge clk);
        rvalid = 1'b0; berr = 1'b0; bus_rdata = '0;
    endtask

    task automatic resp(input string tag, input logic [63:0] erd, input logic ee);
        int n = 0;
        while (!m_rv && n < 20) begin @(negedge clk); n++; end
        lat = cyc - t0;
        check({tag, "_rvalid"}, m_rv, 1);
        check({tag, "_err"}, m_err, ee);
        if (!ee) check({tag, "_rdata"}, m_rdata, erd);
        @(negedge clk);
        check({tag, "_pulse_end"}, m_rv, 0);
    endtask

    initial begin
        rst_n = 1'b0; req_v = '0; wr = 0; zext = 0; size = WORD; addr = '0; wdata = '0;
        gnt = 0; rvalid = 0; berr = 0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {a_busy, b_busy, c_busy}, 0);
        check("rst_req", {a_req, b_req, c_req}, 0);
        check("rst_rvalid", {a_rv, b_rv, c_rv, a_err, b_err, c_err}, 0);
        check("rst_outs", {a_rdata, c_rdata, a_addr, c_be, c_wdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned LW with immediate grant and next-cycle response.
        start(0, 0, WORD, 0, 32'h100, 0);
        beat("lw", 32'h100, 8'h0F, 0, 0, 64'hDEADBEEF, 0, 0);
        resp("lw", 64'hDEADBEEF, 0);
        check("lw_latency", lat, 3);

        start(0, 0, BYTE, 0, 32'h103, 0);
        beat("lb_s", 32'h100, 8'h08, 0, 0, 64'h80123456, 0, 0);
        resp("lb_s", 64'hFFFFFF80, 0);

        start(0, 0, BYTE, 1, 32'h103, 0);
        beat("lb_z", 32'h100, 8'h08, 0, 0, 64'h80123456, 0, 0);
        resp("lb_z", 64'h00000080, 0);

        start(0, 1, WORD, 0, 32'h102, 64'h11223344);
        beat("sw0", 32'h100, 8'h0C, 1, 64'h33440000, 0, 0, 0);
        beat("sw1", 32'h104, 8'h03, 1, 64'h00001122, 0, 0, 0);
        resp("sw", 64'h0, 0);

        start(0, 0, HALF_WORD, 1, 32'h107, 0);
        beat("lh0", 32'h104, 8'h08, 0, 0, 64'hAB000000, 0, 0);
        beat("lh1", 32'h108, 8'h01, 0, 0, 64'h000000CD, 0, 0);
        resp("lh", 64'h0000CDAB, 0);

        // Line-crossing access on the trapping instance: error, no bus traffic.
        rc = req_cnt;
        start(1, 0, HALF_WORD, 1, 32'h107, 0);
        resp("trap", 64'h0, 1);
        check("trap_lat_le2", lat <= 2, 1);
        check("trap_no_bus", req_cnt - rc, 0);

        start(0, 0, WORD, 1, 32'h200, 0);
        beat("hold", 32'h200, 8'h0F, 0, 0, 64'hCAFEF00D, 0, 5);
        resp("hold", 64'hCAFEF00D, 0);

        // Bus error on the first beat of a split access suppresses the second beat.
        start(0, 0, HALF_WORD, 1, 32'h107, 0);
        beat("eb0", 32'h104, 8'h08, 0, 0, 64'hAB000000, 1, 0);
        rc = req_cnt;
        resp("eb0", 64'h0, 1);
        repeat (2) @(negedge clk);
        check("eb0_no_beat1", req_cnt - rc, 0);

        // Reset while waiting for the response.
        start(0, 0, WORD, 0, 32'h300, 0);
        check("rstw_req", m_req, 1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        check("rstw_busy", m_busy, 1);
        rc = rv_cnt;
        rst_n = 1'b0;
        #1;
        check("rstw_async_busy", m_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rvalid = 1'b1; bus_rdata = 64'h12345678;
        @(negedge clk);
        rvalid = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        check("rstw_no_rvalid", rv_cnt - rc, 0);
        check("rstw_idle", m_busy, 0);

        rc = req_cnt;
        start(0, 0, DWORD, 0, 32'h100, 0);
        resp("dw32", 64'h0, 1);
        check("dw32_no_bus", req_cnt - rc, 0);

        // XLEN=64: DWORD crossing the top of the address space wraps to 0.
        start(2, 0, DWORD, 0, 32'hFFFFFFFC, 0);
        beat("ld0", 32'hFFFFFFF8, 8'hF0, 0, 0, 64'h1122334455667788, 0, 0);
        beat("ld1", 32'h00000000, 8'h0F, 0, 0, 64'h99AABBCCDDEEFF00, 0, 0);
        resp("ld", 64'hDDEEFF0011223344, 0);

        start(2, 0, WORD, 0, 32'h10C, 0);
        beat("lw64", 32'h108, 8'hF0, 0, 0, 64'h8765432100000000, 0, 0);
        resp("lw64", 64'hFFFFFFFF87654321, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
